// File: rtl/minx_pkg.sv
// Shared types and constants for the system bus arbiter and its round-robin picker.
package minx_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_CPU = 2'd1,
        GRANT   = 2'd2,
        GAP     = 2'd3
    } arb_state_e;

    // System bus field widths.
    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 8;
    localparam int STATUS_W = 2;

    // Bus command encodings carried on the *_bus_status lines.
    localparam logic [STATUS_W-1:0] BUS_CMD_IDLE  = 2'b00;
    localparam logic [STATUS_W-1:0] BUS_CMD_READ  = 2'b01;
    localparam logic [STATUS_W-1:0] BUS_CMD_WRITE = 2'b10;
    localparam logic [STATUS_W-1:0] BUS_CMD_IACK  = 2'b11;

    // Width of the owner field: 0 is the CPU, k+1 is master k.
    function automatic int owner_width(input int num_masters);
        return (num_masters + 1 > 1) ? $clog2(num_masters + 1) : 1;
    endfunction

    // Width needed to hold a master index; never narrower than one bit.
    function automatic int index_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot winner among the requesters, searching from the
// master after the last winner and wrapping around.
module rr_picker
    import minx_pkg::*;
#(
    parameter int  NUM_MASTERS = 2,
    localparam int IDX_W       = index_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_winner,
    output logic [NUM_MASTERS-1:0] winner,
    output logic                   valid
);

    logic [IDX_W-1:0] cand;

    // Walk offsets 1..NUM_MASTERS so the last winner is considered last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_W'((int'(last_winner) + i) % NUM_MASTERS);
            if (!valid && req[cand]) begin
                winner[cand] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// System bus arbiter: obtains the bus from the CPU on behalf of DMA-style
// masters, hands it out round-robin, and muxes the owner onto the system bus.
module bus_arbiter
    import minx_pkg::*;
#(
    parameter int  NUM_MASTERS = 2,
    localparam int OWNER_W     = owner_width(NUM_MASTERS),
    localparam int IDX_W       = index_width(NUM_MASTERS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_MASTERS-1:0]               m_req,
    output logic [NUM_MASTERS-1:0]               m_gnt,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_data,
    input  logic [NUM_MASTERS-1:0]               m_write,
    input  logic [NUM_MASTERS-1:0]               m_read,
    input  logic [NUM_MASTERS-1:0][STATUS_W-1:0] m_bus_status,
    input  logic [ADDR_W-1:0]                    cpu_address,
    input  logic [DATA_W-1:0]                    cpu_data,
    input  logic                                 cpu_write,
    input  logic                                 cpu_read,
    input  logic [STATUS_W-1:0]                  cpu_bus_status,
    output logic                                 cpu_bus_request,
    input  logic                                 cpu_bus_ack,
    output logic [ADDR_W-1:0]                    bus_address,
    output logic [DATA_W-1:0]                    bus_data,
    output logic                                 bus_write,
    output logic                                 bus_read,
    output logic [STATUS_W-1:0]                  bus_status,
    output logic [OWNER_W-1:0]                   owner,
    output logic                                 ack_lost
);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]       last_winner_q, last_winner_d;
    logic                   cpu_req_q, cpu_req_d;
    logic                   ack_lost_q, ack_lost_d;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       sel_idx;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_picker (
        .req         (m_req),
        .last_winner (last_winner_q),
        .winner      (pick_onehot),
        .valid       (pick_valid)
    );

    // Convert the picker's one-hot winner into a master index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and registered-output logic; grants are only latched when the
    // CPU acknowledges, so a request dropped before that leaves no trace.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        ack_lost_d    = ack_lost_q;
        case (state_q)
            IDLE: begin
                if (|m_req) begin
                    state_d = REQ_CPU;
                end
            end
            REQ_CPU: begin
                if (!(|m_req)) begin
                    state_d = IDLE;
                end else if (cpu_bus_ack && pick_valid) begin
                    state_d       = GRANT;
                    gnt_d         = pick_onehot;
                    owner_d       = OWNER_W'(pick_idx) + OWNER_W'(1);
                    last_winner_d = pick_idx;
                end
            end
            GRANT: begin
                if (!cpu_bus_ack) begin
                    // CPU took the bus back under a master: abandon and flag it.
                    state_d    = IDLE;
                    gnt_d      = '0;
                    owner_d    = '0;
                    ack_lost_d = 1'b1;
                end else if (!(|(m_req & gnt_q))) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    owner_d = '0;
                end
            end
            GAP: begin
                if (cpu_bus_ack && pick_valid) begin
                    state_d       = GRANT;
                    gnt_d         = pick_onehot;
                    owner_d       = OWNER_W'(pick_idx) + OWNER_W'(1);
                    last_winner_d = pick_idx;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
            end
        endcase
        // The CPU is asked to stay off the bus in every state but IDLE.
        cpu_req_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_q       <= '0;
            last_winner_q <= IDX_W'(NUM_MASTERS - 1);
            cpu_req_q     <= 1'b0;
            ack_lost_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            cpu_req_q     <= cpu_req_d;
            ack_lost_q    <= ack_lost_d;
        end
    end

    assign sel_idx = IDX_W'(owner_q - OWNER_W'(1));

    // System bus mux driven from the registered owner; GAP keeps the CPU's
    // address/data/status but suppresses strobes for one quiet cycle.
    always_comb begin
        bus_address = cpu_address;
        bus_data    = cpu_data;
        bus_write   = cpu_write;
        bus_read    = cpu_read;
        bus_status  = cpu_bus_status;
        if (owner_q != '0) begin
            bus_address = m_address[sel_idx];
            bus_data    = m_data[sel_idx];
            bus_write   = m_write[sel_idx];
            bus_read    = m_read[sel_idx];
            bus_status  = m_bus_status[sel_idx];
        end else if (state_q == GAP) begin
            bus_write = 1'b0;
            bus_read  = 1'b0;
        end
    end

    assign m_gnt           = gnt_q;
    assign owner           = owner_q;
    assign cpu_bus_request = cpu_req_q;
    assign ack_lost        = ack_lost_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter with two masters.
module tb_bus_arbiter;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     m_req;
    logic [N-1:0]     m_gnt;
    logic [N-1:0][23:0] m_address;
    logic [N-1:0][7:0]  m_data;
    logic [N-1:0]     m_write;
    logic [N-1:0]     m_read;
    logic [N-1:0][1:0] m_bus_status;
    logic [23:0]      cpu_address;
    logic [7:0]       cpu_data;
    logic             cpu_write;
    logic             cpu_read;
    logic [1:0]       cpu_bus_status;
    logic             cpu_bus_request;
    logic             cpu_bus_ack;
    logic [23:0]      bus_address;
    logic [7:0]       bus_data;
    logic             bus_write;
    logic             bus_read;
    logic [1:0]       bus_status;
    logic [1:0]       owner;
    logic             ack_lost;

    int vectors = 0;
    int miscompares = 0;

    bus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_req          (m_req),
        .m_gnt          (m_gnt),
        .m_address      (m_address),
        .m_data         (m_data),
        .m_write        (m_write),
        .m_read         (m_read),
        .m_bus_status   (m_bus_status),
        .cpu_address    (cpu_address),
        .cpu_data       (cpu_data),
        .cpu_write      (cpu_write),
        .cpu_read       (cpu_read),
        .cpu_bus_status (cpu_bus_status),
        .cpu_bus_request(cpu_bus_request),
        .cpu_bus_ack    (cpu_bus_ack),
        .bus_address    (bus_address),
        .bus_data       (bus_data),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_status     (bus_status),
        .owner          (owner),
        .ack_lost       (ack_lost)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; m_req = '0; cpu_bus_ack = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; m_req = 2'b11; cpu_bus_ack = 1'b1;
        tick(); tick();
        vectors++; if (m_gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", m_gnt); end
        vectors++; if (cpu_bus_request !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_req: got %b want 0", cpu_bus_request); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner: got %0d want 0", owner); end
        vectors++; if (ack_lost !== 1'b0) begin miscompares++; $display("FAIL reset_ack_lost: got %b want 0", ack_lost); end
        vectors++; if (bus_address !== 24'hC0FFEE) begin miscompares++; $display("FAIL reset_bus_addr: got %h want c0ffee", bus_address); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        apply_reset();
        m_req = 2'b01;
        tick();
        vectors++; if (cpu_bus_request !== 1'b1 || m_gnt !== 2'b00) begin miscompares++; $display("FAIL single_req_cpu: got req=%b gnt=%b want req=1 gnt=00", cpu_bus_request, m_gnt); end
        tick();
        vectors++; if (m_gnt !== 2'b00) begin miscompares++; $display("FAIL single_wait_ack: got %b want 00", m_gnt); end
        cpu_bus_ack = 1'b1;
        tick();
        vectors++; if (m_gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b want 01", m_gnt); end
        vectors++; if (owner !== 2'd1) begin miscompares++; $display("FAIL single_owner: got %0d want 1", owner); end
        vectors++; if (bus_address !== 24'h111111 || bus_data !== 8'hA0) begin miscompares++; $display("FAIL single_bus: got %h/%h want 111111/a0", bus_address, bus_data); end
        vectors++; if (bus_write !== 1'b1 || bus_read !== 1'b0 || bus_status !== 2'b01) begin miscompares++; $display("FAIL single_strobes: got w=%b r=%b s=%b want 1 0 01", bus_write, bus_read, bus_status); end
        m_req = 2'b00;
        tick();
        vectors++; if (m_gnt !== 2'b00 || owner !== 2'd0 || cpu_bus_request !== 1'b1) begin miscompares++; $display("FAIL single_gap: got gnt=%b own=%0d req=%b want 00 0 1", m_gnt, owner, cpu_bus_request); end
        vectors++; if (bus_write !== 1'b0 || bus_read !== 1'b0 || bus_status !== 2'b11 || bus_address !== 24'hC0FFEE) begin miscompares++; $display("FAIL single_gap_bus: got w=%b r=%b s=%b a=%h want 0 0 11 c0ffee", bus_write, bus_read, bus_status, bus_address); end
        tick();
        vectors++; if (cpu_bus_request !== 1'b0 || bus_write !== 1'b1) begin miscompares++; $display("FAIL single_idle: got req=%b w=%b want 0 1", cpu_bus_request, bus_write); end
        cpu_bus_ack = 1'b0;
        $display("test_single done");
    endtask

    task automatic test_contention();
        apply_reset();
        m_req = 2'b11; cpu_bus_ack = 1'b1;
        tick(); tick();
        for (int c = 0; c < 4; c++) begin
            vectors++; if (m_gnt !== 2'b01 || cpu_bus_request !== 1'b1) begin miscompares++; $display("FAIL cont_m0_cyc%0d: got gnt=%b req=%b want 01 1", c, m_gnt, cpu_bus_request); end
            if (c < 3) tick();
        end
        m_req = 2'b10;
        tick();
        vectors++; if (m_gnt !== 2'b00 || cpu_bus_request !== 1'b1) begin miscompares++; $display("FAIL cont_gap1: got gnt=%b req=%b want 00 1", m_gnt, cpu_bus_request); end
        tick();
        for (int c = 0; c < 4; c++) begin
            vectors++; if (m_gnt !== 2'b10 || owner !== 2'd2 || cpu_bus_request !== 1'b1) begin miscompares++; $display("FAIL cont_m1_cyc%0d: got gnt=%b own=%0d req=%b want 10 2 1", c, m_gnt, owner, cpu_bus_request); end
            if (c < 3) tick();
        end
        vectors++; if (bus_address !== 24'h222222 || bus_read !== 1'b1 || bus_status !== 2'b10) begin miscompares++; $display("FAIL cont_m1_bus: got a=%h r=%b s=%b want 222222 1 10", bus_address, bus_read, bus_status); end
        m_req = 2'b00;
        tick();
        vectors++; if (m_gnt !== 2'b00 || cpu_bus_request !== 1'b1) begin miscompares++; $display("FAIL cont_gap2: got gnt=%b req=%b want 00 1", m_gnt, cpu_bus_request); end
        tick();
        vectors++; if (cpu_bus_request !== 1'b0) begin miscompares++; $display("FAIL cont_idle: got %b want 0", cpu_bus_request); end
        $display("test_contention done");
    endtask

    task automatic test_fairness();
        apply_reset();
        m_req = 2'b11; cpu_bus_ack = 1'b1;
        tick(); tick();
        vectors++; if (m_gnt !== 2'b01) begin miscompares++; $display("FAIL fair_first: got %b want 01", m_gnt); end
        m_req = 2'b10;
        tick();
        vectors++; if (m_gnt !== 2'b00) begin miscompares++; $display("FAIL fair_gap: got %b want 00", m_gnt); end
        m_req = 2'b11;
        tick();
        vectors++; if (m_gnt !== 2'b10 || owner !== 2'd2) begin miscompares++; $display("FAIL fair_second: got gnt=%b own=%0d want 10 2", m_gnt, owner); end
        m_req = 2'b01;
        tick(); tick();
        vectors++; if (m_gnt !== 2'b01 || owner !== 2'd1) begin miscompares++; $display("FAIL fair_third: got gnt=%b own=%0d want 01 1", m_gnt, owner); end
        m_req = 2'b00;
        tick(); tick();
        cpu_bus_ack = 1'b0;
        $display("test_fairness done");
    endtask

    task automatic test_withdraw();
        apply_reset();
        m_req = 2'b01;
        tick();
        vectors++; if (cpu_bus_request !== 1'b1) begin miscompares++; $display("FAIL wd_req: got %b want 1", cpu_bus_request); end
        m_req = 2'b00;
        tick();
        vectors++; if (cpu_bus_request !== 1'b0 || m_gnt !== 2'b00) begin miscompares++; $display("FAIL wd_idle: got req=%b gnt=%b want 0 00", cpu_bus_request, m_gnt); end
        cpu_bus_ack = 1'b1;
        tick(); tick();
        vectors++; if (m_gnt !== 2'b00 || owner !== 2'd0) begin miscompares++; $display("FAIL wd_nogrant: got gnt=%b own=%0d want 00 0", m_gnt, owner); end
        cpu_bus_ack = 1'b0;
        $display("test_withdraw done");
    endtask

    task automatic test_ack_lost();
        apply_reset();
        m_req = 2'b01; cpu_bus_ack = 1'b1;
        tick(); tick();
        vectors++; if (m_gnt !== 2'b01 || ack_lost !== 1'b0) begin miscompares++; $display("FAIL al_grant: got gnt=%b al=%b want 01 0", m_gnt, ack_lost); end
        cpu_bus_ack = 1'b0;
        tick();
        vectors++; if (m_gnt !== 2'b00 || ack_lost !== 1'b1 || cpu_bus_request !== 1'b0) begin miscompares++; $display("FAIL al_drop: got gnt=%b al=%b req=%b want 00 1 0", m_gnt, ack_lost, cpu_bus_request); end
        tick();
        m_req = 2'b00;
        tick(); tick();
        vectors++; if (ack_lost !== 1'b1) begin miscompares++; $display("FAIL al_sticky: got %b want 1", ack_lost); end
        reset = 1'b0;
        tick();
        vectors++; if (ack_lost !== 1'b0) begin miscompares++; $display("FAIL al_cleared: got %b want 0", ack_lost); end
        reset = 1'b1;
        $display("test_ack_lost done");
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        m_req = 2'b10; cpu_bus_ack = 1'b1;
        tick(); tick();
        vectors++; if (m_gnt !== 2'b10 || bus_address !== 24'h222222) begin miscompares++; $display("FAIL rmg_grant: got gnt=%b a=%h want 10 222222", m_gnt, bus_address); end
        reset = 1'b0;
        tick();
        vectors++; if (m_gnt !== 2'b00 || owner !== 2'd0 || cpu_bus_request !== 1'b0 || ack_lost !== 1'b0) begin miscompares++; $display("FAIL rmg_outputs: got gnt=%b own=%0d req=%b al=%b want 00 0 0 0", m_gnt, owner, cpu_bus_request, ack_lost); end
        vectors++; if (bus_address !== 24'hC0FFEE || bus_data !== 8'h5A || bus_read !== 1'b0 || bus_write !== 1'b1 || bus_status !== 2'b11) begin miscompares++; $display("FAIL rmg_bus: got a=%h d=%h r=%b w=%b s=%b want c0ffee 5a 0 1 11", bus_address, bus_data, bus_read, bus_write, bus_status); end
        reset = 1'b1; m_req = 2'b00; cpu_bus_ack = 1'b0;
        $display("test_reset_mid_grant done");
    endtask

    initial begin
        reset = 1'b0; m_req = '0; cpu_bus_ack = 1'b0;
        m_address[0] = 24'h111111; m_address[1] = 24'h222222;
        m_data[0] = 8'hA0; m_data[1] = 8'hB1;
        m_write = 2'b01; m_read = 2'b10;
        m_bus_status[0] = 2'b01; m_bus_status[1] = 2'b10;
        cpu_address = 24'hC0FFEE; cpu_data = 8'h5A;
        cpu_write = 1'b1; cpu_read = 1'b0; cpu_bus_status = 2'b11;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_withdraw();
        test_ack_lost();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
